// File: rtl/mips_mem_system.sv
// Memory subsystem for a multicycle MIPS core: word RAM plus three MMIO registers.
//   clk, reset     : single clock, synchronous active-high reset
//   adr            : byte address (PC or data address), decoded every cycle
//   memwrite       : store strobe for the current cycle
//   writedata      : store data
//   readdata       : combinational load/fetch data for adr
//   tx_data        : TX FIFO head byte
//   tx_valid       : TX FIFO non-empty
//   tx_ready       : consumer takes the head this cycle
//   bus_err        : sticky flag, set by any access to an unmapped address
// MMIO map: TXDATA 0xFFFF_0000 (write pushes a byte), STATUS 0xFFFF_0004,
// TIMER 0xFFFF_0008 (free-running, writable).
module mips_mem_system #(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr,
    input  logic        memwrite,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_err
);

    localparam int unsigned RamAw  = $clog2(RAM_WORDS);
    localparam int unsigned FifoAw = $clog2(FIFO_DEPTH);

    localparam logic [31:0] AdrTxData = 32'hFFFF_0000;
    localparam logic [31:0] AdrStatus = 32'hFFFF_0004;
    localparam logic [31:0] AdrTimer  = 32'hFFFF_0008;

    localparam logic [FifoAw:0]   CountFull = (FifoAw + 1)'(FIFO_DEPTH);
    localparam logic [FifoAw:0]   CountOne  = (FifoAw + 1)'(1);
    localparam logic [FifoAw-1:0] PtrOne    = FifoAw'(1);

    logic [31:0]       ram_q [RAM_WORDS];
    logic [7:0]        fifo_q [FIFO_DEPTH];
    logic [FifoAw-1:0] wr_ptr_q, wr_ptr_d;
    logic [FifoAw-1:0] rd_ptr_q, rd_ptr_d;
    logic [FifoAw:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              bus_err_q, bus_err_d;
    logic [31:0]       timer_q, timer_d;

    logic        ram_hit, tx_hit, status_hit, timer_hit, unmapped;
    logic        fifo_full, fifo_empty, push_req, push, pop;
    logic [31:0] count_ext;
    logic [2:0]  count_sat;

    // Address decode. RAM occupies the low RAM_WORDS words; adr[1:0] ignored there.
    assign ram_hit    = (adr[31:RamAw+2] == '0);
    assign tx_hit     = (adr == AdrTxData);
    assign status_hit = (adr == AdrStatus);
    assign timer_hit  = (adr == AdrTimer);
    assign unmapped   = !(ram_hit || tx_hit || status_hit || timer_hit);

    assign fifo_full  = (count_q == CountFull);
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && tx_ready;
    assign push_req   = memwrite && tx_hit;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push       = push_req && (!fifo_full || pop);

    assign count_ext = 32'(count_q);
    assign count_sat = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CountOne;
        end else if (pop && !push) begin
            count_d = count_q - CountOne;
        end
        overflow_d = overflow_q || (push_req && fifo_full && !pop);
        bus_err_d  = bus_err_q || unmapped;
        // A TIMER store replaces the increment for that edge.
        timer_d    = (memwrite && timer_hit) ? writedata : timer_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            bus_err_q  <= 1'b0;
            timer_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            bus_err_q  <= bus_err_d;
            timer_q    <= timer_d;
        end
    end

    // Storage arrays are not reset; reset still blocks writes on its edge.
    always_ff @(posedge clk) begin
        if (!reset && memwrite && ram_hit) begin
            ram_q[adr[RamAw+1:2]] <= writedata;
        end
        if (!reset && push) begin
            fifo_q[wr_ptr_q] <= writedata[7:0];
        end
    end

    always_comb begin
        readdata = '0;
        if (ram_hit) begin
            readdata = ram_q[adr[RamAw+1:2]];
        end else if (status_hit) begin
            readdata = {26'd0, overflow_q, count_sat, fifo_empty, fifo_full};
        end else if (timer_hit) begin
            readdata = timer_q;
        end
    end

    assign tx_data  = fifo_q[rd_ptr_q];
    assign tx_valid = !fifo_empty;
    assign bus_err  = bus_err_q;

endmodule

// File: doc/mips_mem_system.md
MIPS_MEM_SYSTEM -- requirements
Module: mips_mem_system

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 64, meaning RAM depth in 32-bit words (power of 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning TX FIFO entries (power of 2, >=2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port adr, input, 32, byte address from the processor (PC or data address).
REQ-006 SHALL have port memwrite, input, 1, write strobe for the current cycle.
REQ-007 SHALL have port writedata, input, 32, store data.
REQ-008 SHALL have port readdata, output, 32, load/fetch data for adr.
REQ-009 SHALL have port tx_data, output, 8, FIFO head byte.
REQ-010 SHALL have port tx_valid, output, 1, FIFO non-empty.
REQ-011 SHALL have port tx_ready, input, 1, consumer accepts head this cycle.
REQ-012 SHALL have port bus_err, output, 1, sticky unmapped-access flag.

Function
REQ-013 SHALL decode adr as RAM when adr[31:2] < RAM_WORDS (word index adr[log2(RAM_WORDS)+1:2]); adr[1:0] ignored.
REQ-014 SHALL map TXDATA at 0xFFFF_0000, STATUS at 0xFFFF_0004, TIMER at 0xFFFF_0008; all other addresses unmapped.
REQ-015 SHALL drive readdata combinationally from adr and current state (zero-wait, same cycle) so the multicycle datapath captures it at the cycle-ending edge.
REQ-016 SHALL write the RAM word on the clock edge when memwrite=1 and adr is in RAM; RAM contents are not cleared by reset.
REQ-017 SHALL return 0 on reads of TXDATA and of unmapped addresses.
REQ-018 SHALL return STATUS = {26'b0, overflow, count[2:0], empty, full}, i.e. bit0 full, bit1 empty, bits[4:2] count (saturated to 7), bit5 overflow.
REQ-019 SHALL push writedata[7:0] into the FIFO when memwrite=1, adr=TXDATA, and FIFO not full (or full with a same-cycle pop).
REQ-020 SHALL drop a TXDATA write when full with no same-cycle pop and set sticky overflow.
REQ-021 SHALL pop the head when tx_valid=1 and tx_ready=1; tx_ready while empty has no effect.
REQ-022 SHALL apply simultaneous push and pop in one edge, count unchanged, pointers wrap modulo FIFO_DEPTH.
REQ-023 SHALL provide no bypass: a push into an empty FIFO raises tx_valid on the following cycle.
REQ-024 SHALL hold tx_data stable while tx_valid=1 and tx_ready=0.
REQ-025 SHALL increment TIMER by 1 every cycle, wrapping 0xFFFF_FFFF -> 0.
REQ-026 SHALL load TIMER with writedata on memwrite to TIMER, no increment that edge; value increments from the next edge.
REQ-027 SHALL ignore writes to STATUS and unmapped addresses, except that unmapped writes and reads both set bus_err.
REQ-028 SHALL treat bus_err as sticky until reset; STATUS write does not clear overflow or bus_err.

Reset
REQ-029 SHALL on reset=1 at an edge set TIMER=0, FIFO pointers/count=0, overflow=0, bus_err=0, so tx_valid=0 and STATUS reads 0x0000_0002 the next cycle.
REQ-030 SHALL give reset priority over same-cycle writes, pushes and pops; a FIFO entry in flight is discarded.

Verification
REQ-031 SHALL verify RAM: write 0xDEAD_BEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 -> both 0xDEAD_BEEF; read 0x0000_0014 unaffected.
REQ-032 SHALL verify FIFO: tx_ready=0, write 0x41,0x42,0x43,0x44,0x45 to TXDATA -> STATUS=0x0000_0031 (full, count 4, overflow); then tx_ready=1 -> tx_data 0x41..0x44 on consecutive cycles, then tx_valid=0.
REQ-033 SHALL verify simultaneous push/pop when full: push 0x55 while popping -> count stays 4, 0x55 emerges last, overflow unchanged.
REQ-034 SHALL verify TIMER: write 0xFFFF_FFFE -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on the next three cycles.
REQ-035 SHALL verify bus_err: read 0x0000_1000 -> readdata 0, bus_err=1 next cycle and held until reset.
REQ-036 SHALL verify reset mid-operation: FIFO holding 3 bytes, TIMER=100, reset one cycle -> tx_valid=0, TIMER=0, STATUS=0x0000_0002, earlier RAM write still readable.
